serial_adder: RTL
=================

# serial_adder

Bit-serial N-bit adder built around a single full-adder cell (two `half_adder` instances plus an OR gate) and a carry flip-flop. It accepts two operands and a carry-in through a valid/ready handshake and adds one bit per clock, LSB first. It then presents the sum, carry-out and signed-overflow flag through a second valid/ready handshake. It is the multi-cycle arithmetic stage that sits directly downstream of the `half_adder` primitive and upstream of the register-file write-back path.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 1–32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: operands on `a`, `b`, `cin` are valid.
- `in_ready` output 1: block can accept operands; high only in IDLE.
- `a` input WIDTH: operand A, unsigned or two's complement.
- `b` input WIDTH: operand B.
- `cin` input 1: carry-in.
- `out_valid` output 1: result is valid; high only in DONE.
- `out_ready` input 1: consumer accepts the result.
- `sum` output WIDTH: (a + b + cin) mod 2^WIDTH.
- `cout` output 1: carry out of bit WIDTH-1.
- `ovf` output 1: signed overflow, equal to carry into bit WIDTH-1 XOR `cout`.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: `in_ready`=0, `out_valid`=0.
  - DONE: `out_valid`=1.
- IDLE -> RUN when `in_valid && in_ready` at a rising edge.
  - `a`, `b` load into shift registers `a_sh`, `b_sh`.
  - `cin` loads into the carry flop; bit counter clears to 0.
- RUN, once per cycle:
  - Full adder computes `s`, `c` from `a_sh[0]`, `b_sh[0]`, `carry`.
  - `s` shifts into `sum_sh` from the MSB side; `a_sh` and `b_sh` shift right by one.
  - `carry` <= `c`; counter increments.
  - On the cycle the counter equals WIDTH-1: capture `carry` (carry into MSB) into `c_msb`, latch `cout` = `c`, then go to DONE.
- DONE:
  - `sum`, `cout`, `ovf` are held stable while `out_valid && !out_ready`.
  - DONE -> IDLE when `out_ready`=1. In that cycle `in_ready` stays 0; no same-cycle re-accept.
- Operand inputs are sampled only at acceptance. Changes on `a`, `b`, `cin` during RUN or DONE have no effect.
- `in_valid` while not in IDLE is ignored and does not need to be held by the block.
- `rst` at any time, including mid-RUN or in DONE, aborts the operation. The next state is IDLE.
- Reset values:
  - State: IDLE.
  - `in_ready`: 1 (combinational from state).
  - `out_valid`: 0.
  - `sum`: 0; `cout`: 0; `ovf`: 0.
  - Internal shift registers, carry flop and counter: 0.
- WIDTH=1: RUN lasts exactly one cycle; `c_msb` = `cin`.

## Timing
- Acceptance at edge k. RUN occupies the cycles following edges k … k+WIDTH-1. `out_valid` is first high after edge k+WIDTH.
- Accept-to-result latency: WIDTH cycles.
- Minimum issue interval, with `out_ready` tied high: WIDTH+2 cycles (accept, WIDTH RUN cycles, one DONE cycle, then IDLE).
- `in_ready` and `out_valid` are registered-state decodes with no combinational path from `in_valid` or `out_ready`.
- The full-adder path (two half adders plus OR) is the only combinational logic between flops in the datapath.

## Structure
- Shared package `cpu_pkg`:
  - state encoding constants `SA_IDLE`=2'd0, `SA_RUN`=2'd1, `SA_DONE`=2'd2;
  - default width constant `CPU_XLEN`=8.
- Counter width: `$clog2(WIDTH)` with a minimum of 1.
- One sub-module: `full_adder` (ports `a`, `b`, `cin`, `sum`, `cout`), built from two existing `half_adder` instances. It is reusable by later ripple-carry blocks.
- The top level contains the FSM, counter, shift registers and carry flop.

## Test plan
- WIDTH=8, `a`=0x0F, `b`=0x01, `cin`=0 -> after 8 cycles `sum`=0x10, `cout`=0, `ovf`=0; `out_valid` rises exactly 8 edges after acceptance.
- `a`=0xFF, `b`=0x01, `cin`=0 -> `sum`=0x00, `cout`=1, `ovf`=0. Then `a`=0x7F, `b`=0x00, `cin`=1 -> `sum`=0x80, `cout`=0, `ovf`=1.
- `a`=0x80, `b`=0x80, `cin`=0 -> `sum`=0x00, `cout`=1, `ovf`=1. Toggle `a`/`b` every cycle during RUN -> result unchanged.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE -> `out_valid`, `sum`, `cout`, `ovf` stable. `in_valid`=1 throughout is not accepted until the cycle after `out_ready` is asserted.
- Assert `rst` for one cycle on the 3rd RUN cycle -> next cycle `in_ready`=1, `out_valid`=0, `sum`=0. A new add of 0x03+0x04 then yields 0x07.
- Back-to-back with `out_ready`=1 and `in_valid`=1 constantly -> one acceptance every 10 cycles (WIDTH+2), results correct for a sequence of 20 random operand pairs checked against `a+b+cin`.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM state encodings and default datapath width
package cpu_pkg;
  localparam int CPU_XLEN = 8;
  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_RUN  = 2'd1,
    SA_DONE = 2'd2
  } sa_state_t;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand and result valid/ready handshakes of the serial adder
interface serial_adder_if import cpu_pkg::*; #(
  parameter int WIDTH = CPU_XLEN
);
  logic in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [WIDTH-1:0] a, b, sum;
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/full_adder.sv
// full_adder: two half adders chained, carries merged with an OR
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s0, c0, c1;
  half_adder ha0 (.a(a), .b(b), .sum(s0), .cout(c0));
  half_adder ha1 (.a(s0), .b(cin), .sum(sum), .cout(c1));
  assign cout = c0 | c1;
endmodule

// File: rtl/half_adder.sv
// half_adder: one-bit sum and carry of two inputs
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);
  assign sum = a ^ b;
  assign cout = a & b;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder step per clock, LSB first
module serial_adder import cpu_pkg::*; #(
  parameter int WIDTH = CPU_XLEN
) (
  input  logic clk,
  input  logic rst,
  serial_adder_if.slave bus
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  sa_state_t state;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CW-1:0] cnt;
  logic carry, c_msb, cout_q, s, c;
  full_adder fa (.a(a_sh[0]), .b(b_sh[0]), .cin(carry), .sum(s), .cout(c));
  assign bus.in_ready = state == SA_IDLE;
  assign bus.out_valid = state == SA_DONE;
  assign bus.sum = sum_sh;
  assign bus.cout = cout_q;
  assign bus.ovf = c_msb ^ cout_q;
  // control FSM and serial datapath: load on accept, one bit per RUN cycle, hold in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SA_IDLE;
      a_sh <= '0;
      b_sh <= '0;
      sum_sh <= '0;
      cnt <= '0;
      carry <= 1'b0;
      c_msb <= 1'b0;
      cout_q <= 1'b0;
    end else if (state == SA_IDLE) begin
      if (bus.in_valid) begin
        a_sh <= bus.a;
        b_sh <= bus.b;
        carry <= bus.cin;
        cnt <= '0;
        state <= SA_RUN;
      end
    end else if (state == SA_RUN) begin
      sum_sh <= (sum_sh >> 1) | (WIDTH'(s) << (WIDTH - 1));
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      carry <= c;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        c_msb <= carry;
        cout_q <= c;
        state <= SA_DONE;
      end
    end else if (state == SA_DONE) begin
      if (bus.out_ready) state <= SA_IDLE;
    end else begin
      state <= SA_IDLE;
    end
  end
endmodule
